fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Instruction fetch front end. It sits between the instruction memory port and the IF/ID pipeline register, and keeps a small prefetch queue of `{instruction, PC+4}` pairs. It absorbs variable memory latency and ID-stage stalls. On a branch or jump redirect from the MEM stage, it flushes all wrong-path state.

## Interface
Parameters:
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word-aligned fetch address; held stable while `imem_req` is high and not yet acked.
- `imem_ack`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; arrives ≥1 cycle after the matching ack.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  branch/jump taken, from the MEM-stage PC mux.
- `redirect_pc`  in  32  new fetch target.
- `stall`  in  1  ID-stage data stall; head entry is held.
- `instr_valid`  out  1  queue head valid.
- `instr_out`  out  32  head instruction; 32'h0 (NOP) when empty.
- `npc_out`  out  32  head PC+4; 32'h0 when empty.

## Operation
- Behaviour is controlled by a three-state FSM:
  - **FETCH**: `imem_req` = (`count + 0 < DEPTH`) & `!redirect`. On `imem_ack`, go to **WAIT**.
  - **WAIT**: one request is outstanding. On `imem_rvalid`, push `{imem_rdata, fetch_pc+4}`, increment `fetch_pc` by 4, and go to **FETCH**.
  - **DROP**: a stale response is outstanding. On `imem_rvalid`, discard the data and go to **FETCH**.
- The unit has at most one outstanding request. Because no request issues unless the queue has room, a push never overflows.
- `imem_addr` = `fetch_pc`.
- **Pop**: occurs when `instr_valid & !stall & !redirect`.
  - Push and pop in the same cycle leave `count` unchanged.
- **Redirect** has highest priority over everything else:
  - `count` ← 0 (queue flushed) and `fetch_pc` ← `redirect_pc`.
  - From **WAIT**, go to **DROP**.
  - If `imem_ack` is high in the same cycle as the redirect, go to **DROP**.
  - If `imem_rvalid` is high in the same cycle as the redirect, the data is discarded.
  - Otherwise, go to **FETCH**.
- A redirect while in **DROP** stays in **DROP** and updates `fetch_pc`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Queue pointers wrap modulo `DEPTH`.
- `redirect_pc[1:0]` is ignored (forced to 0).

## Timing
- **Reset values**: `imem_req`=0, `instr_valid`=0, `instr_out`=0, `npc_out`=0, state=**FETCH**, `fetch_pc`=`RESET_PC`, `count`=0.
- The first `imem_req` occurs in the first cycle after `rst_n` deasserts.
- **Fetch latency**: with ack in cycle N and rvalid in cycle M > N, the entry is visible at the head in cycle M+1.
- **Redirect latency**: redirect in cycle N gives `imem_req` with `imem_addr`=`redirect_pc` in cycle N+1, unless in **DROP**.
- In cycle N+1 after a redirect, `instr_valid`=0.
- Head outputs come from queue flops through the read-pointer mux. There is no combinational path from `imem_rdata` to `instr_out`.
- **Full queue** (`count`=`DEPTH`): `imem_req`=0 until a pop.
- **Empty queue**: `instr_valid`=0; `stall` has no effect.
- Reset asserted mid-transaction: all state clears immediately. The memory side must also be reset.

## Structure
- Package `fetch_pkg` holds:
  - `NOP_INSTR` = 32'h0.
  - State enum `fetch_state_e` {FETCH, WAIT, DROP}.
  - Struct `fetch_entry_t` {instr[31:0], npc[31:0]}.
- Sub-module `fetch_queue`: parameterised synchronous FIFO with push, pop, flush, count, head data, and asynchronous active-low reset.
- The FSM, PC register, and request logic live in the top module.

## Test plan
- **Reset and fill**: reset, memory acks immediately with rvalid one cycle later, `stall`=1, `DEPTH`=4.
  - Fetches 0, 4, 8, 0xC, then `imem_req`=0.
  - Head `instr_out`=mem[0], `npc_out`=4.
- **Steady stream**: `stall`=0, one-cycle memory. Consecutive heads show `npc_out` = 4, 8, 12, …, with no gaps after fill.
- **Redirect during WAIT**: redirect to 0x100 while waiting.
  - The old rvalid is dropped.
  - The next `imem_addr`=0x100.
  - The first valid head has `npc_out`=0x104.
- **Redirect coinciding with ack**: response is dropped; the next request is to `redirect_pc`. The queue is empty in the next cycle.
- **Stall versus redirect in the same cycle**: the queue is flushed and no pop is counted. `instr_valid`=0 in the next cycle.
- **Wrap**: redirect to 0xFFFF_FFFC. The entry has `npc_out`=0, and the next fetch address is 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: small synchronous FIFO of {instruction, PC+4} entries.
// The head is read straight from the storage flops; an empty queue shows NOP.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push & (r_count != FULL_CNT);
    assign w_pop  = i_pop  & (r_count != '0);

    // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed through the valid-masked head mux.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '{instr: NOP_INSTR, npc: 32'h0};

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: single-outstanding memory requester feeding a
// prefetch queue, with redirect flush of all wrong-path state.
//
// state | meaning
// FETCH | idle or requesting; issues a request when the queue has room
// WAIT  | one request acked, waiting for its read data
// DROP  | a stale (pre-redirect) response is outstanding and will be discarded
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_state_e  r_state;
    fetch_state_e  w_next_state;
    logic [31:0]   r_fetch_pc;
    logic          r_req_en;

    logic          w_push;
    logic          w_pop;
    logic          w_has_room;
    logic          w_q_valid;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;

    assign w_has_room  = (w_count < FULL_CNT);
    assign w_pop       = w_q_valid & ~stall & ~redirect;
    assign w_push_data = '{instr: imem_rdata, npc: r_fetch_pc + 32'd4};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_next_state;
    end

    // Fetch PC and request enable; requests start on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_en   <= 1'b0;
        end else begin
            r_req_en <= 1'b1;
            if (redirect)
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (r_state == WAIT && imem_rvalid)
                r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Next state. A redirect leaves DROP pending only if a response is still in
    // flight afterwards: a fresh ack, or an older request whose data has not
    // arrived this very cycle.
    always_comb begin
        w_next_state = r_state;
        if (redirect) begin
            if ((r_state == FETCH && imem_ack) || (r_state != FETCH && !imem_rvalid))
                w_next_state = DROP;
            else
                w_next_state = FETCH;
        end else begin
            case (r_state)
                FETCH:   if (imem_req && imem_ack) w_next_state = WAIT;
                WAIT:    if (imem_rvalid)          w_next_state = FETCH;
                DROP:    if (imem_rvalid)          w_next_state = FETCH;
                default: w_next_state = FETCH;
            endcase
        end
    end

    // Outputs: request issue and queue push.
    always_comb begin
        imem_req = 1'b0;
        w_push   = 1'b0;
        case (r_state)
            FETCH:   imem_req = r_req_en & w_has_room & ~redirect;
            WAIT:    w_push   = imem_rvalid & ~redirect;
            default: ;
        endcase
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_valid (w_q_valid),
        .o_count (w_count)
    );

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = w_q_valid;
    assign instr_out   = w_head.instr;
    assign npc_out     = w_head.npc;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a simple latency-programmable memory.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] npc_out;

    int total = 0;
    int bad   = 0;

    bit          pending;
    logic [31:0] p_addr;
    int          p_cnt;
    int          mem_lat;
    bit          ack_force;
    logic [31:0] ack_addr;

    fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .npc_out     (npc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: retire last cycle's handshakes, drive this cycle's inputs,
    // then let the memory answer the (settled) request. Returns mid-cycle.
    task automatic tick(input bit rd, input logic [31:0] rpc, input bit st);
        @(posedge clk);
        #1;
        if (imem_rvalid) pending = 1'b0;
        if (imem_ack) begin
            pending = 1'b1;
            p_addr  = ack_addr;
            p_cnt   = mem_lat;
        end
        redirect    = rd;
        redirect_pc = rpc;
        stall       = st;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pending) begin
            p_cnt = p_cnt - 1;
            if (p_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(p_addr);
            end
        end
        #1;
        imem_ack = ack_force | (imem_req & ~pending);
        ack_addr = imem_addr;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        pending     = 1'b0;
        p_addr      = 32'h0;
        p_cnt       = 0;
        mem_lat     = 1;
        ack_force   = 1'b0;
        ack_addr    = 32'h0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_req",   {31'h0, imem_req},    32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr_out,            32'h0);
        chk("rst_npc",   npc_out,              32'h0);
        chk("rst_addr",  imem_addr,            32'h0);

        // Reset and fill with the head stalled.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 32'h0, 1'b1);
            chk($sformatf("fill_req%0d", k),  {31'h0, imem_req}, 32'h1);
            chk($sformatf("fill_addr%0d", k), imem_addr,         32'(4 * k));
            tick(1'b0, 32'h0, 1'b1);
        end
        tick(1'b0, 32'h0, 1'b1);
        chk("full_req",   {31'h0, imem_req},    32'h0);
        chk("full_valid", {31'h0, instr_valid}, 32'h1);
        chk("full_instr", instr_out,            32'hC0DE_0000);
        chk("full_npc",   npc_out,              32'h4);
        tick(1'b0, 32'h0, 1'b1);
        chk("full_hold_req", {31'h0, imem_req}, 32'h0);
        chk("full_hold_npc", npc_out,           32'h4);

        // Steady stream: consecutive heads with no gaps.
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, 32'h0, 1'b0);
            chk($sformatf("strm_valid%0d", k), {31'h0, instr_valid}, 32'h1);
            chk($sformatf("strm_npc%0d", k),   npc_out,              32'(4 * k));
            chk($sformatf("strm_instr%0d", k), instr_out,            32'hC0DE_0000 | 32'(4 * k - 4));
        end

        // Redirect while WAIT with a slow memory; low target bits are ignored.
        mem_lat = 3;
        tick(1'b1, 32'h0000_0103, 1'b1);
        chk("rw_req_at_redirect", {31'h0, imem_req}, 32'h0);
        tick(1'b0, 32'h0, 1'b1);
        chk("rw_valid_n1", {31'h0, instr_valid}, 32'h0);
        chk("rw_req_drop", {31'h0, imem_req},    32'h0);
        tick(1'b0, 32'h0, 1'b1);
        chk("rw_stale_rvalid", {31'h0, imem_rvalid}, 32'h1);
        chk("rw_req_drop2",    {31'h0, imem_req},    32'h0);
        mem_lat = 1;
        tick(1'b0, 32'h0, 1'b1);
        chk("rw_req",    {31'h0, imem_req},    32'h1);
        chk("rw_addr",   imem_addr,            32'h0000_0100);
        chk("rw_dropped",{31'h0, instr_valid}, 32'h0);
        tick(1'b0, 32'h0, 1'b1);

        // Redirect coinciding with an ack.
        ack_force = 1'b1;
        tick(1'b1, 32'h0000_0200, 1'b1);
        ack_force = 1'b0;
        chk("rw_head_valid", {31'h0, instr_valid}, 32'h1);
        chk("rw_head_npc",   npc_out,              32'h0000_0104);
        chk("rw_head_instr", instr_out,            32'hC0DE_0100);
        tick(1'b0, 32'h0, 1'b1);
        chk("ra_valid_n1", {31'h0, instr_valid}, 32'h0);
        chk("ra_req_drop", {31'h0, imem_req},    32'h0);
        tick(1'b0, 32'h0, 1'b1);
        chk("ra_req",   {31'h0, imem_req},    32'h1);
        chk("ra_addr",  imem_addr,            32'h0000_0200);
        chk("ra_empty", {31'h0, instr_valid}, 32'h0);
        tick(1'b0, 32'h0, 1'b1);

        // Stall and redirect together, target at the top of the address space.
        tick(1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("sr_head_valid", {31'h0, instr_valid}, 32'h1);
        chk("sr_head_npc",   npc_out,              32'h0000_0204);
        tick(1'b0, 32'h0, 1'b1);
        chk("sr_valid_n1", {31'h0, instr_valid}, 32'h0);
        chk("sr_nop",      instr_out,            32'h0);
        chk("sr_npc0",     npc_out,              32'h0);
        chk("sr_req",      {31'h0, imem_req},    32'h1);
        chk("sr_addr",     imem_addr,            32'hFFFF_FFFC);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        chk("wrap_valid", {31'h0, instr_valid}, 32'h1);
        chk("wrap_instr", instr_out,            32'hC0DE_FFFC);
        chk("wrap_npc",   npc_out,              32'h0);
        chk("wrap_addr",  imem_addr,            32'h0);
        chk("wrap_req",   {31'h0, imem_req},    32'h1);

        // Asynchronous reset in the middle of a transaction.
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        pending     = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("mid_rst_req",   {31'h0, imem_req},    32'h0);
        chk("mid_rst_instr", instr_out,            32'h0);
        chk("mid_rst_addr",  imem_addr,            32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
